// File: rtl/seq_mag_compare.sv
// seq_mag_compare: multi-cycle magnitude comparator, SLICE bits per clock,
// MSB slice first with early termination. Supports unsigned or two's-complement
// operands and a cascade input from a less-significant stage.
//
// Ports:
//   clk                  clock, rising edge
//   rst                  synchronous active-high reset
//   start                request a comparison (accepted only when idle)
//   a, b                 operands, WIDTH bits, sampled on accepted start
//   signed_mode          1 = two's-complement compare, 0 = unsigned
//   i_agb, i_alb, i_aeb  cascade inputs, used when all slices are equal
//   busy                 high while a comparison is in flight or completing
//   done                 one-cycle pulse, result flags valid
//   agb, alb, aeb        registered result flags, held until the next result
module seq_mag_compare #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             i_agb,
  input  logic             i_alb,
  input  logic             i_aeb,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             alb,
  output logic             aeb
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

  // Reject operand widths that do not split into whole slices.
  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("seq_mag_compare: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sm_q, sm_d;
  logic [2:0]       cas_q, cas_d;     // {agb, alb, aeb}
  logic [2:0]       flags_q, flags_d; // {agb, alb, aeb}
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] sa_c, sb_c;

  // Cascade resolution when every slice compared equal, highest priority first.
  function automatic logic [2:0] resolve(input logic [2:0] c);
    if (c[0])                 return 3'b001;
    else if (c[2] && !c[1])   return 3'b100;
    else if (!c[2] && c[1])   return 3'b010;
    else if (c[2] && c[1])    return 3'b000;
    else                      return 3'b110;
  endfunction

  // Current slice; the top slice's MSB is flipped so signed order maps to unsigned.
  always_comb begin
    sa_c = a_q[idx_q*SLICE +: SLICE];
    sb_c = b_q[idx_q*SLICE +: SLICE];
    if (sm_q && (idx_q == IDX_TOP)) begin
      sa_c[SLICE-1] = ~sa_c[SLICE-1];
      sb_c[SLICE-1] = ~sb_c[SLICE-1];
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    cas_d   = cas_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          cas_d   = {i_agb, i_alb, i_aeb};
          idx_d   = IDX_TOP;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sa_c > sb_c) begin
          flags_d = 3'b100;
          state_d = DONE;
        end else if (sa_c < sb_c) begin
          flags_d = 3'b010;
          state_d = DONE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else begin
          flags_d = resolve(cas_q);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      cas_q   <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      cas_q   <= cas_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign agb  = flags_q[2];
  assign alb  = flags_q[1];
  assign aeb  = flags_q[0];

endmodule

// File: tb/tb_seq_mag_compare.sv
// Testbench for seq_mag_compare (WIDTH=16, SLICE=4): directed vectors with
// hand-computed flags and slice counts pushed to a scoreboard queue; a monitor
// pops and checks on every done pulse.
module tb_seq_mag_compare;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        signed_mode;
  logic        i_agb, i_alb, i_aeb;
  logic        busy, done, agb, alb, aeb;

  seq_mag_compare #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .i_agb(i_agb), .i_alb(i_alb), .i_aeb(i_aeb),
    .busy(busy), .done(done), .agb(agb), .alb(alb), .aeb(aeb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  flags;  // {agb, alb, aeb}
    logic [7:0]  k;      // slices examined
    logic [31:0] acc;    // cycle count after the accepting edge
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [2:0]  last_flags = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no outstanding request at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({agb, alb, aeb} !== e.flags) begin
          n_fail++;
          $display("FAIL flags: got %b required %b", {agb, alb, aeb}, e.flags);
        end
        n_tests++;
        if ((cyc - e.acc) != 32'(e.k)) begin
          n_fail++;
          $display("FAIL latency: got %0d edges required %0d", cyc - e.acc, e.k);
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  task automatic scramble();
    a           = 16'($urandom);
    b           = 16'($urandom);
    signed_mode = 1'($urandom);
    {i_agb, i_alb, i_aeb} = 3'($urandom);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_%s: %0d outstanding after %0d cycles", name, sb_q.size(), n);
      sb_q.delete();
    end
  endtask

  // Issue one comparison, scramble inputs while busy, wait for the result.
  task automatic run_cmp(input string name, input logic [15:0] ta, input logic [15:0] tb,
                         input logic sm, input logic [2:0] cas,
                         input logic [2:0] flags, input int k);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb; signed_mode = sm; {i_agb, i_alb, i_aeb} = cas;
    start = 1'b1;
    e.flags = flags; e.k = 8'(k); e.acc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    scramble();
    // Flags must still hold the previous result while the new compare runs.
    check({name, "_hold"}, {busy, agb, alb, aeb}, {1'b1, last_flags});
    wait_empty(name);
    last_flags = flags;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0; {i_agb, i_alb, i_aeb} = 3'b000;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, agb, alb, aeb}, 4'b0000);
    check("reset_done", {3'b000, done}, 4'b0000);
    rst = 1'b0;

    //      name        a        b        sm    cascade  flags   k
    run_cmp("msb_gt",  16'h8000, 16'h7FFF, 1'b0, 3'b000, 3'b100, 1);
    run_cmp("lsb_lt",  16'h1234, 16'h1235, 1'b0, 3'b000, 3'b010, 4);
    run_cmp("eq_ceq",  16'hABCD, 16'hABCD, 1'b0, 3'b001, 3'b001, 4);
    run_cmp("eq_c110", 16'hABCD, 16'hABCD, 1'b0, 3'b110, 3'b000, 4);
    run_cmp("eq_c000", 16'hABCD, 16'hABCD, 1'b0, 3'b000, 3'b110, 4);
    run_cmp("eq_c100", 16'h5A5A, 16'h5A5A, 1'b0, 3'b100, 3'b100, 4);
    run_cmp("eq_c010", 16'h5A5A, 16'h5A5A, 1'b0, 3'b010, 3'b010, 4);
    run_cmp("eq_c111", 16'h0000, 16'h0000, 1'b0, 3'b111, 3'b001, 4);
    run_cmp("s_neg",   16'hFFFF, 16'h0001, 1'b1, 3'b000, 3'b010, 1);
    run_cmp("u_neg",   16'hFFFF, 16'h0001, 1'b0, 3'b000, 3'b100, 1);
    run_cmp("k2_lt",   16'h1200, 16'h1300, 1'b0, 3'b001, 3'b010, 2);
    run_cmp("k3_gt",   16'h12A4, 16'h1294, 1'b0, 3'b001, 3'b100, 3);
    run_cmp("s_max",   16'h7FFF, 16'h8000, 1'b1, 3'b000, 3'b100, 1);
    run_cmp("s_low",   16'h8001, 16'h8000, 1'b1, 3'b010, 3'b100, 4);
    run_cmp("s_eqneg", 16'h8000, 16'h8000, 1'b1, 3'b100, 3'b100, 4);

    // Hold flags after a completed result with no activity.
    repeat (3) @(negedge clk);
    check("flags_hold_idle", {busy, agb, alb, aeb}, {1'b0, last_flags});

    // start held high throughout a 4-slice compare; inputs change while busy.
    begin
      exp_t e;
      int   n;
      @(negedge clk);
      a = 16'h1234; b = 16'h1235; signed_mode = 1'b0; {i_agb, i_alb, i_aeb} = 3'b000;
      start = 1'b1;
      e.flags = 3'b010; e.k = 8'd4; e.acc = cyc + 1;
      sb_q.push_back(e);
      n = 0;
      do begin
        @(negedge clk); #1;
        scramble();
        n++;
      end while (!done && n < 40);
      check("busy_start_done_seen", {3'b000, done}, 4'b0001);
      // Cycle after done is idle: the still-high start is accepted at its end.
      @(negedge clk);
      a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0; {i_agb, i_alb, i_aeb} = 3'b000;
      check("idle_after_done", {busy, agb, alb, aeb}, 4'b0010);
      e.flags = 3'b100; e.k = 8'd1; e.acc = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wait_empty("restart");
      last_flags = 3'b100;
    end

    // Reset while RUN at index 2 aborts the compare with no done pulse.
    @(negedge clk);
    a = 16'h1234; b = 16'h1235; signed_mode = 1'b0; {i_agb, i_alb, i_aeb} = 3'b000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_abort_busy", {busy, agb, alb, aeb}, 4'b1100);
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", {busy, agb, alb, aeb}, 4'b0000);
    check("abort_done", {3'b000, done}, 4'b0000);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_quiet", {busy, agb, alb, aeb}, 4'b0000);
    last_flags = 3'b000;

    // First start after reset accepted immediately.
    run_cmp("post_rst", 16'h0001, 16'h0002, 1'b0, 3'b000, 3'b010, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
